// File: rtl/module_uart_rx_if.sv
// Byte/status bundle between the UART receiver and the RX control FSM.
// master = receiver (drives byte and flags), slave = control FSM (drives the clear).
interface module_uart_rx_if;
    logic [7:0] rx_data_o;
    logic       rx_data_rdy_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       new_rx_clear_i;

    modport master (
        output rx_data_o,
        output rx_data_rdy_o,
        output frame_err_o,
        output overrun_o,
        input  new_rx_clear_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_data_rdy_o,
        input  frame_err_o,
        input  overrun_o,
        output new_rx_clear_i
    );
endinterface

// File: rtl/module_uart_rx.sv
// 8N1 UART receiver, LSB first, fixed divisor, mid-bit sampling.
// Holds the last good byte with sticky ready/overrun flags cleared by the RX control FSM.
module module_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             rx_i,
    module_uart_rx_if.master rx_bus
);

    localparam logic [CNT_W-1:0] BitTerm  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HalfTerm = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    logic [1:0]       sync_q;
    logic             rx_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;

    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             byte_done;
    logic             stop_bad;
    logic             clear;

    assign rx_s  = sync_q[1];
    assign clear = rx_bus.new_rx_clear_i;

    // Receive FSM: timing and bit capture only, no knowledge of the clear handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            StStart: begin
                if (cnt_q == HalfTerm) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StData: begin
                if (cnt_q == BitTerm) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StStop: begin
                if (cnt_q == BitTerm) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StWaitHigh: begin
                // A break must not look like a new start bit.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Completion wins over clear: a byte landing during a clear is a fresh, unread byte.
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        ovr_d  = ovr_q;
        ferr_d = stop_bad;

        if (byte_done) begin
            data_d = shift_q;
            if (clear) begin
                rdy_d = 1'b1;
                ovr_d = 1'b0;
            end else if (rdy_q) begin
                ovr_d = 1'b1;
            end else begin
                rdy_d = 1'b1;
            end
        end else if (clear) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_bus.rx_data_o     = data_q;
    assign rx_bus.rx_data_rdy_o = rdy_q;
    assign rx_bus.frame_err_o   = ferr_q;
    assign rx_bus.overrun_o     = ovr_q;

endmodule

// File: tb/tb_module_uart_rx.sv
// Self-checking bench for module_uart_rx: directed frames plus random frames,
// compared against a frame-level model of the data/ready/overrun/frame-error rules.
module tb_module_uart_rx;

    localparam int Cpb      = 16;
    localparam int FrameLen = 10 * Cpb;
    // Frame cycle whose closing edge registers the completed byte (2 sync + idle detect).
    localparam int DoneIter = Cpb / 2 + 9 * Cpb + 2;

    logic clk_i = 1'b0;
    logic reset_i;
    logic rx_i;

    module_uart_rx_if rx_bus ();

    module_uart_rx #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .rx_i    (rx_i),
        .rx_bus  (rx_bus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fall_cyc;
    int rise_cyc;
    bit rdy_prev = 1'b0;

    // Frame-error pulse monitor, sampled on the falling edge.
    int ferr_cnt = 0;
    int ferr_wide = 0;
    logic ferr_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rx_bus.frame_err_o === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
            if (ferr_prev === 1'b1) ferr_wide <= ferr_wide + 1;
        end
        ferr_prev <= rx_bus.frame_err_o;
    end

    // Reference model state
    logic [7:0] m_data;
    bit m_rdy;
    bit m_ovr;
    int m_ferr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_data"}, 32'(rx_bus.rx_data_o), 32'(m_data));
        check_val({tag, "_rdy"}, 32'(rx_bus.rx_data_rdy_o), 32'(m_rdy));
        check_val({tag, "_ovr"}, 32'(rx_bus.overrun_o), 32'(m_ovr));
        check_val({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'(m_ferr));
        check_val({tag, "_ferr_wide"}, 32'(ferr_wide), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        if (rx_bus.rx_data_rdy_o && !rdy_prev && rise_cyc < 0) rise_cyc = cyc;
        rdy_prev = rx_bus.rx_data_rdy_o;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_clear();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_done(input logic [7:0] b, input bit with_clear);
        m_data = b;
        if (with_clear) begin
            m_rdy = 1'b1;
            m_ovr = 1'b0;
        end else if (m_rdy) begin
            m_ovr = 1'b1;
        end else begin
            m_rdy = 1'b1;
        end
    endtask

    task automatic pulse_clear(input int n);
        rx_bus.new_rx_clear_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rx_bus.new_rx_clear_i = 1'b0;
        model_clear();
    endtask

    // One 8N1 frame; clear_at/reset_at select the frame cycle they are held for (-1 = none).
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int clear_at,
                              input int reset_at, input int tail);
        logic [2:0] bi;
        fall_cyc = cyc;
        rise_cyc = -1;
        for (int o = 0; o < FrameLen + tail; o++) begin
            if (o < Cpb) begin
                rx_i = 1'b0;
            end else if (o < 9 * Cpb) begin
                bi   = 3'((o - Cpb) / Cpb);
                rx_i = b[bi];
            end else if (o < FrameLen) begin
                rx_i = stop_ok;
            end else begin
                rx_i = 1'b0;
            end
            rx_bus.new_rx_clear_i = (o == clear_at);
            reset_i = (o == reset_at);
            tick();
            if (o == reset_at) begin
                reset_i = 1'b0;
                model_reset();
                check_outputs("midreset");
            end
        end
        rx_i = 1'b1;
        rx_bus.new_rx_clear_i = 1'b0;
        if (reset_at < 0) begin
            if (stop_ok) begin
                if (clear_at >= 0 && clear_at < DoneIter) model_clear();
                model_done(b, clear_at == DoneIter);
                if (clear_at > DoneIter) model_clear();
            end else begin
                m_ferr++;
                if (clear_at >= 0) model_clear();
            end
        end
    endtask

    initial begin
        int lat;
        logic [7:0] rb;
        bit rs;
        int rc;
        int sel;

        reset_i = 1'b1;
        rx_i    = 1'b1;
        rx_bus.new_rx_clear_i = 1'b0;
        model_reset();
        m_ferr = 0;
        rise_cyc = 0;
        for (int i = 0; i < 3; i++) tick();
        reset_i = 1'b0;
        tick();
        check_outputs("reset");

        // 1: good 0xA5, latency, clear
        send_frame(8'hA5, 1'b1, -1, -1, 0);
        idle(2);
        lat = rise_cyc - fall_cyc;
        check_val("t1_latency_ok", 32'(lat >= DoneIter && lat <= DoneIter + 2), 32'd1);
        check_outputs("t1");
        pulse_clear(2);
        tick();
        check_outputs("t1_clr");

        // 2: short glitch rejected
        rx_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        idle(40);
        check_outputs("t2");

        // 3: bad stop with long low tail, then a good byte
        send_frame(8'h3C, 1'b0, -1, -1, 40);
        idle(6);
        check_outputs("t3_ferr");
        send_frame(8'h81, 1'b1, -1, -1, 0);
        idle(4);
        check_outputs("t3_next");
        pulse_clear(1);

        // 4: back-to-back overrun
        send_frame(8'h3C, 1'b1, -1, -1, 0);
        send_frame(8'hC3, 1'b1, -1, -1, 0);
        idle(4);
        check_outputs("t4_ovr");
        pulse_clear(1);
        tick();
        check_outputs("t4_clr");

        // 5: clear coinciding with completion while overrun is pending
        send_frame(8'h12, 1'b1, -1, -1, 0);
        send_frame(8'h34, 1'b1, -1, -1, 0);
        send_frame(8'h55, 1'b1, DoneIter, -1, 0);
        idle(4);
        check_outputs("t5");

        // 6: reset during data bit 4, then a clean byte
        send_frame(8'hF0, 1'b1, -1, Cpb + 4 * Cpb + 5, 0);
        idle(20);
        check_outputs("t6_abort");
        send_frame(8'h0F, 1'b1, -1, -1, 0);
        idle(4);
        check_outputs("t6_next");

        // Random frames
        for (int n = 0; n < 30; n++) begin
            rb  = 8'($urandom);
            rs  = ($urandom_range(0, 7) != 0);
            sel = int'($urandom_range(0, 3));
            rc  = (sel == 1) ? DoneIter : (sel == 2) ? int'($urandom_range(0, FrameLen - 1)) : -1;
            send_frame(rb, rs, rc, -1, rs ? 0 : int'($urandom_range(0, 30)));
            idle(rs ? int'($urandom_range(0, 10)) : int'($urandom_range(4, 12)));
            check_outputs($sformatf("rnd%0d", n));
            if (sel == 3) pulse_clear(int'($urandom_range(1, 3)));
        end
        idle(4);
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
